fta_req_arbiter: RTL and testbench
==================================

Name: fta_req_arbiter

Overview:
- Round-robin arbiter sharing one 128-bit FTA command channel (e.g. the DRAM channel-7 path or CPU-side I/O bus) among NREQ bus masters.
- Registers the winning request and holds it until downstream accepts.
- Tags each request with a per-master cid and routes returning responses back by cid.
- Tracks outstanding transactions per master and enforces a per-master limit.

Parameters:
- NREQ, 4, number of requesting masters (2..8).
- MAX_OUTST, 4, max outstanding transactions per master (1..15).
- CID_BASE, 4'd1, cid assigned to master 0; master i gets CID_BASE+i (4-bit, must not wrap).
- TIMEOUT, 1023, watchdog cycles; used only with FTA_ARB_TIMEOUT_EN.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- s_req  input  [NREQ-1:0] fta_cmd_request128_t  master requests; held stable while cyc&stb until s_accept.
- s_accept  output  [NREQ-1:0]  one-cycle pulse: master i's request was captured.
- s_resp  output  [NREQ-1:0] fta_cmd_response128_t  per-master routed responses.
- m_req  output  fta_cmd_request128_t  registered request to the shared target.
- m_rdy  input  1  target accepts m_req this cycle when m_req.stb=1.
- m_resp  input  fta_cmd_response128_t  target response stream.
- outst_o  output  [NREQ*4-1:0]  per-master outstanding counts (debug).
- bad_cid_o  output  1  sticky: response with unmapped cid seen.

Behaviour:
- Reset: m_req='0, s_accept=0, s_resp all '0, outstanding counts 0, rr pointer=0, bad_cid_o=0, FSM=IDLE.
- Eligible(i) = s_req[i].cyc & s_req[i].stb & (outst[i] < MAX_OUTST).
- FSM IDLE: if any eligible, pick the first eligible index at or after rr pointer (wrapping modulo NREQ).
  - Capture s_req[winner] into m_req, overriding cid with CID_BASE+winner.
  - Pulse s_accept[winner] for that same cycle, increment outst[winner], set rr=winner+1 (mod NREQ), go to HOLD.
  - If none eligible, m_req.cyc/stb=0.
- FSM HOLD: m_req stays stable.
  - On m_rdy: clear m_req.cyc/stb and return to IDLE; no new grant in this cycle.
  - Minimum grant spacing is 2 cycles.
- Latency: master request to m_req valid = 1 cycle.
- Response routing: when m_resp.ack=1 and cid==CID_BASE+i, drive s_resp[i]=m_resp for exactly that cycle (registered, 1-cycle latency) and decrement outst[i]. All other s_resp[j] have ack=0.
- Simultaneous increment and decrement on the same master: count unchanged.
- Decrement at count 0 is suppressed and sets bad_cid_o.
- Unmapped cid with ack=1: response dropped, bad_cid_o set; it clears only on rst.
- Master at MAX_OUTST is skipped; the rr pointer does not stall on it.
- Master deasserting cyc while not accepted: no effect. Requests are not revocable after s_accept.
- Reset mid-HOLD: m_req dropped immediately on the next edge, counters cleared, and in-flight responses after reset are treated as unmapped only if their count is 0.

Optional Feature:
- Macro FTA_ARB_TIMEOUT_EN.
- With it: a per-master 10-bit watchdog runs while outst[i]>0.
  - The watchdog reloads on any response to master i.
  - On reaching TIMEOUT it injects a synthetic s_resp[i] with ack=1, err=1, dat=all ones, cid=CID_BASE+i, decrements outst[i] and restarts.
  - If the injection coincides with a real response for that master, the real response wins and the watchdog reloads.
- Without it: no watchdog logic; a lost response permanently consumes one outstanding slot.

Test Plan:
- Single master 0 read, m_rdy=1: m_req valid with cid=1 the cycle after the request; s_accept[0] pulse; response cid=1 appears on s_resp[0] 1 cycle later; outst[0] 0->1->0.
- Masters 0..3 all requesting continuously, m_rdy=1, responses returned immediately: grants 0,1,2,3,0,… with 2-cycle spacing; each s_accept seen once per rotation.
- MAX_OUTST=2, master 1 issues 3 requests with no responses: third is not accepted; other masters still granted; after one response with cid=2, third is accepted.
- m_rdy held 0 for 5 cycles: m_req unchanged for 5 cycles, no new s_accept; on m_rdy=1, FSM returns to IDLE and next grant follows.
- Response with cid=4'hF (unmapped), then a response to a master with count 0: both dropped, bad_cid_o=1 and stays set until rst.
- FTA_ARB_TIMEOUT_EN, TIMEOUT=16, master 2 request never answered: at 16 cycles, synthetic err response on s_resp[2] and outst[2] returns to 0.

Source files
------------

// File: rtl/fta_pkg.sv
// fta_pkg: FTA 128-bit command request/response bundles.
// Shared by the channel arbiter and its masters.
package fta_pkg;

    typedef struct packed {
        logic         cyc;
        logic         stb;
        logic         we;
        logic [3:0]   cid;
        logic [31:0]  adr;
        logic [15:0]  sel;
        logic [127:0] dat;
    } fta_cmd_request128_t;

    typedef struct packed {
        logic         ack;
        logic         err;
        logic [3:0]   cid;
        logic [31:0]  adr;
        logic [127:0] dat;
    } fta_cmd_response128_t;

endpackage

// File: rtl/fta_req_arbiter.sv
// fta_req_arbiter: round-robin arbiter for one shared 128-bit FTA command channel.
// Define FTA_ARB_TIMEOUT_EN to add a per-master response watchdog.
module fta_req_arbiter
    import fta_pkg::*;
#(
    parameter int         NREQ      = 4,
    parameter int         MAX_OUTST = 4,
    parameter logic [3:0] CID_BASE  = 4'd1,
    parameter int         TIMEOUT   = 1023
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  fta_cmd_request128_t  [NREQ-1:0]      s_req,
    output logic                 [NREQ-1:0]      s_accept,
    output fta_cmd_response128_t [NREQ-1:0]      s_resp,
    output fta_cmd_request128_t                  m_req,
    input  logic                                 m_rdy,
    input  fta_cmd_response128_t                 m_resp,
    output logic                 [NREQ*4-1:0]    outst_o,
    output logic                                 bad_cid_o
);

    localparam int IW = $clog2(NREQ);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   rr_q, win;
    logic            found, grant;
    logic [NREQ-1:0] elig, fwd, dec;
    logic [3:0]      outst [NREQ];

    if (NREQ < 2 || NREQ > 8 || MAX_OUTST < 1 || MAX_OUTST > 15 ||
        TIMEOUT < 1 || TIMEOUT > 1023 ||
        int'(CID_BASE) + NREQ > 16) begin : g_bad_param
        $error("fta_req_arbiter: parameter out of range");
    end

    always_comb begin
        elig = '0;
        fwd  = '0;
        for (int i = 0; i < NREQ; i++) begin
            elig[i] = s_req[i].cyc & s_req[i].stb &
                      (outst[i] < 4'(MAX_OUTST));
            // a response to an idle master is treated as unmapped
            fwd[i]  = m_resp.ack & (outst[i] != 4'd0) &
                      (m_resp.cid == CID_BASE + 4'(i));
        end
    end

    always_comb begin
        int j;
        found = 1'b0;
        win   = '0;
        j     = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(rr_q) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!found && elig[IW'(j)]) begin
                found = 1'b1;
                win   = IW'(j);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        grant    = 1'b0;
        s_accept = '0;
        unique case (state_q)
            IDLE: begin
                if (found && !rst) begin
                    grant         = 1'b1;
                    s_accept[win] = 1'b1;
                    state_d       = HOLD;
                end
            end
            HOLD: begin
                if (m_rdy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rr_q      <= '0;
            m_req     <= '0;
            bad_cid_o <= 1'b0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                m_req     <= s_req[win];
                m_req.cid <= CID_BASE + 4'(win);
                rr_q      <= (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;
            end else if (state_q == HOLD && m_rdy) begin
                m_req.cyc <= 1'b0;
                m_req.stb <= 1'b0;
            end
            if (m_resp.ack && !(|fwd)) bad_cid_o <= 1'b1;
        end
    end

    for (genvar i = 0; i < NREQ; i++) begin : g_mst
        logic [3:0]           cnt_q;
        logic                 inc;
        fta_cmd_response128_t rsp_q, rsp_d;

        assign inc = grant & (win == IW'(i));

`ifdef FTA_ARB_TIMEOUT_EN
        logic [9:0] wd_q;
        logic       inj;

        // a real response in the same cycle beats the synthetic one
        assign inj = (cnt_q != 4'd0) & ~fwd[i] &
                     (wd_q == 10'(TIMEOUT - 1));

        always_ff @(posedge clk) begin
            if (rst || cnt_q == 4'd0 || fwd[i] || inj) wd_q <= '0;
            else wd_q <= wd_q + 10'd1;
        end

        assign dec[i] = fwd[i] | inj;

        always_comb begin
            rsp_d = '0;
            if (fwd[i]) begin
                rsp_d = m_resp;
            end else if (inj) begin
                rsp_d.ack = 1'b1;
                rsp_d.err = 1'b1;
                rsp_d.cid = CID_BASE + 4'(i);
                rsp_d.dat = '1;
            end
        end
`else
        assign dec[i] = fwd[i];

        always_comb begin
            rsp_d = '0;
            if (fwd[i]) rsp_d = m_resp;
        end
`endif

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_q <= '0;
                rsp_q <= '0;
            end else begin
                cnt_q <= cnt_q + 4'(inc) - 4'(dec[i]);
                rsp_q <= rsp_d;
            end
        end

        assign outst[i]          = cnt_q;
        assign outst_o[4*i +: 4] = cnt_q;
        assign s_resp[i]         = rsp_q;
    end

endmodule

// File: tb/tb_fta_req_arbiter.sv
// tb_fta_req_arbiter: vector table, corner sequences and randomized run
// against a behavioural model of the round-robin channel arbiter.
module tb_fta_req_arbiter;
    import fta_pkg::*;

    localparam int         NREQ = 4;
    localparam int         MAXO = 2;
    localparam logic [3:0] CB   = 4'd1;
    localparam int         TMO  = 16;

    typedef logic [703:0] wide_t;

    logic                                 clk = 1'b0;
    logic                                 rst = 1'b1;
    fta_cmd_request128_t  [NREQ-1:0]      s_req;
    logic                 [NREQ-1:0]      s_accept;
    fta_cmd_response128_t [NREQ-1:0]      s_resp;
    fta_cmd_request128_t                  m_req;
    logic                                 m_rdy;
    fta_cmd_response128_t                 m_resp;
    logic                 [NREQ*4-1:0]    outst_o;
    logic                                 bad_cid_o;

    fta_req_arbiter #(
        .NREQ(NREQ), .MAX_OUTST(MAXO), .CID_BASE(CB), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .s_req(s_req), .s_accept(s_accept), .s_resp(s_resp),
        .m_req(m_req), .m_rdy(m_rdy), .m_resp(m_resp),
        .outst_o(outst_o), .bad_cid_o(bad_cid_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(string name, wide_t act, wide_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic fta_cmd_request128_t mkreq(int i, bit v, logic [31:0] a);
        fta_cmd_request128_t r;
        r     = '0;
        r.cyc = v;
        r.stb = v;
        r.we  = i[0];
        r.cid = 4'hE;
        r.adr = a;
        r.sel = '1;
        r.dat = {4{a ^ 32'(i)}};
        return r;
    endfunction

    task automatic set_req(logic [NREQ-1:0] mask, logic [31:0] base);
        for (int i = 0; i < NREQ; i++)
            s_req[i] = mkreq(i, mask[i], base + 32'(i));
    endtask

    task automatic set_resp(bit ack, logic [3:0] cid);
        m_resp     = '0;
        m_resp.ack = ack;
        m_resp.cid = cid;
        m_resp.err = 1'($urandom_range(0, 1));
        m_resp.adr = $urandom;
        m_resp.dat = {$urandom, $urandom, $urandom, $urandom};
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not end");
        $fatal(1, "timeout");
    end

`ifdef FTA_ARB_TIMEOUT_EN
    initial begin
        int n;
        n = 0;
        m_rdy = 1'b1;
        set_req('0, 32'h0);
        set_resp(1'b0, 4'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        set_req(4'b0100, 32'hB000_0000);
        @(negedge clk);
        chk("to_accept", wide_t'(s_accept), wide_t'(4'b0100));
        @(posedge clk); #1;
        set_req('0, 32'h0);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) chk("to_outst_busy", wide_t'(outst_o[11:8]), wide_t'(4'd1));
            if (s_resp[2].ack) begin
                n = c;
                break;
            end
        end
        chk("to_seen", wide_t'(n != 0), wide_t'(1'b1));
        chk("to_delay", wide_t'(n - 1), wide_t'(TMO));
        chk("to_resp", wide_t'({s_resp[2].err, s_resp[2].cid, s_resp[2].dat}),
            wide_t'({1'b1, 4'd3, {128{1'b1}}}));
        chk("to_others", wide_t'({s_resp[3].ack, s_resp[1].ack, s_resp[0].ack}),
            wide_t'(3'b000));
        chk("to_outst_free", wide_t'(outst_o[11:8]), wide_t'(4'd0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
`else
    int                   mo [NREQ];
    int                   mrr;
    bit                   mhold;
    bit                   mbad;
    fta_cmd_request128_t  em;
    fta_cmd_response128_t [NREQ-1:0] es;

    task automatic model_reset();
        for (int i = 0; i < NREQ; i++) mo[i] = 0;
        mrr   = 0;
        mhold = 1'b0;
        mbad  = 1'b0;
        em    = '0;
        es    = '0;
    endtask

    function automatic int pick();
        for (int k = 0; k < NREQ; k++) begin
            int i = (mrr + k) % NREQ;
            if (s_req[i].cyc && s_req[i].stb && mo[i] < MAXO) return i;
        end
        return -1;
    endfunction

    function automatic logic [NREQ*4-1:0] mpack();
        logic [NREQ*4-1:0] p;
        for (int i = 0; i < NREQ; i++) p[4*i +: 4] = 4'(mo[i]);
        return p;
    endfunction

    // call at the negedge with inputs stable; returns just after the next posedge
    task automatic step();
        int w;
        int k;
        logic [NREQ-1:0] ea;
        w = -1;
        if (!rst && !mhold) w = pick();
        ea = '0;
        if (w >= 0) ea[w] = 1'b1;
        chk("s_accept", wide_t'(s_accept), wide_t'(ea));
        chk("m_req", wide_t'(m_req), wide_t'(em));
        chk("s_resp", wide_t'(s_resp), wide_t'(es));
        chk("outst", wide_t'(outst_o), wide_t'(mpack()));
        chk("bad_cid", wide_t'(bad_cid_o), wide_t'(mbad));
        if (rst) begin
            model_reset();
        end else begin
            es = '0;
            k  = int'(m_resp.cid) - int'(CB);
            if (m_resp.ack) begin
                if (k >= 0 && k < NREQ && mo[k] > 0) begin
                    es[k] = m_resp;
                    mo[k]--;
                end else begin
                    mbad = 1'b1;
                end
            end
            if (w >= 0) begin
                em     = s_req[w];
                em.cid = CB + 4'(w);
                mo[w]++;
                mrr    = (w + 1) % NREQ;
                mhold  = 1'b1;
            end else if (mhold && m_rdy) begin
                em.cyc = 1'b0;
                em.stb = 1'b0;
                mhold  = 1'b0;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        m_rdy = 1'b1;
        set_req('0, 32'h0);
        set_resp(1'b0, 4'h0);
        @(negedge clk);
        step();
        rst = 1'b0;
    endtask

    typedef struct {
        bit        rst;
        bit [3:0]  req;
        bit        rdy;
        bit        ack;
        bit [3:0]  cid;
        bit [3:0]  acc;
        bit        cyc;
        bit [3:0]  mcid;
        bit [15:0] outst;
        bit [3:0]  rack;
        bit        bad;
    } vec_t;

    vec_t vt [27];

    initial begin
        logic [NREQ-1:0] ea;
        int r;

        // rst req rdy ack cid | acc cyc mcid outst rack bad
        vt[0]  = '{1, 4'b0000, 1, 0, 4'h0, 4'b0000, 0, 4'h0, 16'h0000, 4'b0000, 0};
        vt[1]  = '{0, 4'b0001, 1, 0, 4'h0, 4'b0001, 0, 4'h0, 16'h0000, 4'b0000, 0};
        vt[2]  = '{0, 4'b0000, 1, 0, 4'h0, 4'b0000, 1, 4'h1, 16'h0001, 4'b0000, 0};
        vt[3]  = '{0, 4'b0000, 1, 1, 4'h1, 4'b0000, 0, 4'h1, 16'h0001, 4'b0000, 0};
        vt[4]  = '{0, 4'b0000, 1, 0, 4'h0, 4'b0000, 0, 4'h1, 16'h0000, 4'b0001, 0};
        vt[5]  = '{0, 4'b1111, 1, 0, 4'h0, 4'b0010, 0, 4'h1, 16'h0000, 4'b0000, 0};
        vt[6]  = '{0, 4'b1111, 1, 0, 4'h0, 4'b0000, 1, 4'h2, 16'h0010, 4'b0000, 0};
        vt[7]  = '{0, 4'b1111, 1, 0, 4'h0, 4'b0100, 0, 4'h2, 16'h0010, 4'b0000, 0};
        vt[8]  = '{0, 4'b1111, 0, 0, 4'h0, 4'b0000, 1, 4'h3, 16'h0110, 4'b0000, 0};
        vt[9]  = '{0, 4'b1111, 0, 0, 4'h0, 4'b0000, 1, 4'h3, 16'h0110, 4'b0000, 0};
        vt[10] = '{0, 4'b1111, 1, 1, 4'h2, 4'b0000, 1, 4'h3, 16'h0110, 4'b0000, 0};
        vt[11] = '{0, 4'b1111, 1, 0, 4'h0, 4'b1000, 0, 4'h3, 16'h0100, 4'b0010, 0};
        vt[12] = '{0, 4'b1111, 1, 1, 4'hF, 4'b0000, 1, 4'h4, 16'h1100, 4'b0000, 0};
        vt[13] = '{0, 4'b1111, 1, 0, 4'h0, 4'b0001, 0, 4'h4, 16'h1100, 4'b0000, 1};
        vt[14] = '{0, 4'b1111, 1, 1, 4'h2, 4'b0000, 1, 4'h1, 16'h1101, 4'b0000, 1};
        vt[15] = '{0, 4'b1111, 1, 0, 4'h0, 4'b0010, 0, 4'h1, 16'h1101, 4'b0000, 1};
        vt[16] = '{0, 4'b1111, 1, 0, 4'h0, 4'b0000, 1, 4'h2, 16'h1111, 4'b0000, 1};
        vt[17] = '{0, 4'b0010, 1, 0, 4'h0, 4'b0010, 0, 4'h2, 16'h1111, 4'b0000, 1};
        vt[18] = '{0, 4'b0010, 1, 0, 4'h0, 4'b0000, 1, 4'h2, 16'h1121, 4'b0000, 1};
        vt[19] = '{0, 4'b0010, 1, 0, 4'h0, 4'b0000, 0, 4'h2, 16'h1121, 4'b0000, 1};
        vt[20] = '{0, 4'b0010, 1, 1, 4'h2, 4'b0000, 0, 4'h2, 16'h1121, 4'b0000, 1};
        vt[21] = '{0, 4'b0010, 1, 0, 4'h0, 4'b0010, 0, 4'h2, 16'h1111, 4'b0010, 1};
        vt[22] = '{0, 4'b0000, 1, 1, 4'h2, 4'b0000, 1, 4'h2, 16'h1121, 4'b0000, 1};
        vt[23] = '{0, 4'b0001, 1, 1, 4'h1, 4'b0001, 0, 4'h2, 16'h1111, 4'b0010, 1};
        vt[24] = '{0, 4'b0000, 0, 0, 4'h0, 4'b0000, 1, 4'h1, 16'h1111, 4'b0001, 1};
        vt[25] = '{1, 4'b0000, 0, 0, 4'h0, 4'b0000, 1, 4'h1, 16'h1111, 4'b0000, 1};
        vt[26] = '{0, 4'b0000, 1, 0, 4'h0, 4'b0000, 0, 4'h0, 16'h0000, 4'b0000, 0};

        m_rdy = 1'b1;
        set_req('0, 32'h0);
        set_resp(1'b0, 4'h0);
        @(posedge clk); #1;
        model_reset();

        for (int n = 0; n < 27; n++) begin
            rst   = vt[n].rst;
            m_rdy = vt[n].rdy;
            set_req(vt[n].req, 32'h1000_0000);
            set_resp(vt[n].ack, vt[n].cid);
            @(negedge clk);
            chk($sformatf("vec%0d_acc", n), wide_t'(s_accept), wide_t'(vt[n].acc));
            chk($sformatf("vec%0d_cyc", n), wide_t'(m_req.cyc), wide_t'(vt[n].cyc));
            chk($sformatf("vec%0d_cid", n), wide_t'(m_req.cid), wide_t'(vt[n].mcid));
            chk($sformatf("vec%0d_outst", n), wide_t'(outst_o), wide_t'(vt[n].outst));
            chk($sformatf("vec%0d_rack", n),
                wide_t'({s_resp[3].ack, s_resp[2].ack, s_resp[1].ack, s_resp[0].ack}),
                wide_t'(vt[n].rack));
            chk($sformatf("vec%0d_bad", n), wide_t'(bad_cid_o), wide_t'(vt[n].bad));
            step();
        end

        // all masters busy, target answers each command at once
        do_reset();
        for (int c = 0; c < 16; c++) begin
            set_req(4'b1111, 32'h2000_0000 + 32'(c << 4));
            m_rdy = 1'b1;
            set_resp(m_req.cyc && m_req.stb, m_req.cid);
            @(negedge clk);
            ea = '0;
            if (c % 2 == 0) ea[(c / 2) % NREQ] = 1'b1;
            chk($sformatf("rot%0d", c), wide_t'(s_accept), wide_t'(ea));
            step();
        end

        // target stalls for five cycles while other masters wait
        do_reset();
        m_rdy = 1'b0;
        set_req(4'b0100, 32'hA000_0000);
        @(negedge clk);
        chk("stall_grant", wide_t'(s_accept), wide_t'(4'b0100));
        step();
        set_req(4'b1011, 32'hA000_0000);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("stall%0d_acc", c), wide_t'(s_accept), wide_t'(4'b0000));
            chk($sformatf("stall%0d_mreq", c),
                wide_t'({m_req.stb, m_req.cid, m_req.adr}),
                wide_t'({1'b1, 4'd3, 32'hA000_0002}));
            step();
        end
        m_rdy = 1'b1;
        @(negedge clk);
        chk("stall_release", wide_t'(s_accept), wide_t'(4'b0000));
        step();
        @(negedge clk);
        chk("stall_next", wide_t'(s_accept), wide_t'(4'b1000));
        step();

        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < NREQ; i++)
                s_req[i] = mkreq(i, $urandom_range(0, 2) != 0, $urandom);
            m_rdy = ($urandom_range(0, 3) != 0);
            r = int'($urandom_range(0, 9));
            set_resp($urandom_range(0, 2) == 0,
                     (r < 8) ? CB + 4'(r % NREQ) : ((r == 8) ? 4'h0 : 4'hF));
            @(negedge clk);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
`endif

endmodule
